// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO feeding the UART transmitter from the APB data register.
// Occupancy is kept in its own counter and every status output is registered.
module uart_tx_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_en_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       almost_full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       ovf_o,
  output logic                       udf_o,
  input  logic                       clr_err_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(AF_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              empty_r;
  logic              full_r;
  logic              almost_full_r;
  logic              ovf_r;
  logic              udf_r;

  logic              rd_acc_s;
  logic              wr_acc_s;
  logic [CW-1:0]     count_nxt_s;
  logic              ovf_nxt_s;
  logic              udf_nxt_s;

  // Accept/reject decisions come only from registered state, never from the outputs' own inputs.
  always_comb begin
    rd_acc_s    = 1'b0;
    wr_acc_s    = 1'b0;
    count_nxt_s = count_r;
    ovf_nxt_s   = ovf_r;
    udf_nxt_s   = udf_r;

    rd_acc_s = rd_en_i && !empty_r;
    wr_acc_s = wr_en_i && (!full_r || rd_acc_s);

    if (wr_acc_s && !rd_acc_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (rd_acc_s && !wr_acc_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end

    // A fresh error in the same cycle as clr_err_i keeps the flag set.
    if (wr_en_i && !wr_acc_s) begin
      ovf_nxt_s = 1'b1;
    end else if (clr_err_i) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end

    if (rd_en_i && empty_r) begin
      udf_nxt_s = 1'b1;
    end else if (clr_err_i) begin
      udf_nxt_s = 1'b0;
    end else begin
      udf_nxt_s = udf_r;
    end
  end

  // Storage array: no reset, written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && wr_acc_s) begin
      mem[wr_ptr_r] <= wr_data_i;
    end
  end

  // Pointers, occupancy, status flags and read data register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
      rd_data_r     <= '0;
      empty_r       <= 1'b1;
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      ovf_r         <= 1'b0;
      udf_r         <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
      empty_r       <= 1'b1;
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      ovf_r         <= 1'b0;
      udf_r         <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r  <= rd_ptr_r + AW'(1);
        rd_data_r <= mem[rd_ptr_r];
      end
      count_r       <= count_nxt_s;
      empty_r       <= (count_nxt_s == '0);
      full_r        <= (count_nxt_s == DEPTH_C);
      almost_full_r <= (count_nxt_s >= THRESH_C);
      ovf_r         <= ovf_nxt_s;
      udf_r         <= udf_nxt_s;
    end
  end

  assign rd_data_o     = rd_data_r;
  assign empty_o       = empty_r;
  assign full_o        = full_r;
  assign almost_full_o = almost_full_r;
  assign count_o       = count_r;
  assign ovf_o         = ovf_r;
  assign udf_o         = udf_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the FIFO.
module tb_uart_tx_fifo;

  localparam int DEPTH     = 16;
  localparam int AF_THRESH = 12;

  logic       clk_i = 1'b0;
  logic       rst_i, flush_i, wr_en_i, rd_en_i, clr_err_i;
  logic [7:0] wr_data_i;
  logic [7:0] rd_data_o;
  logic       empty_o, full_o, almost_full_o, ovf_o, udf_o;
  logic [4:0] count_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] m_rd_data;
  logic       m_ovf, m_udf;

  uart_tx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .rd_en_i(rd_en_i),
    .rd_data_o(rd_data_o), .empty_o(empty_o), .full_o(full_o),
    .almost_full_o(almost_full_o), .count_o(count_o),
    .ovf_o(ovf_o), .udf_o(udf_o), .clr_err_i(clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one clock edge worth of FIFO behaviour.
  task automatic model_step(input logic rst, flush, wr, input logic [7:0] wd,
                            input logic rd, clr);
    bit was_full, was_empty, rd_ok, wr_ok;
    if (rst) begin
      q.delete(); m_rd_data = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (flush) begin
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      rd_ok = rd && !was_empty;
      wr_ok = wr && (!was_full || rd_ok);
      if (rd_ok) m_rd_data = q.pop_front();
      if (wr_ok) q.push_back(wd);
      m_ovf = (wr && !wr_ok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_udf = (rd && was_empty) ? 1'b1 : (clr ? 1'b0 : m_udf);
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".count"}, 32'(count_o), 32'(q.size()));
    check_eq({tag, ".empty"}, 32'(empty_o), 32'(q.size() == 0));
    check_eq({tag, ".full"},  32'(full_o),  32'(q.size() == DEPTH));
    check_eq({tag, ".af"},    32'(almost_full_o), 32'(q.size() >= AF_THRESH));
    check_eq({tag, ".rdata"}, 32'(rd_data_o), 32'(m_rd_data));
    check_eq({tag, ".ovf"},   32'(ovf_o), 32'(m_ovf));
    check_eq({tag, ".udf"},   32'(udf_o), 32'(m_udf));
  endtask

  task automatic cycle(input string tag, input logic rst, flush, wr,
                       input logic [7:0] wd, input logic rd, clr);
    rst_i = rst; flush_i = flush; wr_en_i = wr; wr_data_i = wd;
    rd_en_i = rd; clr_err_i = clr;
    @(posedge clk_i);
    model_step(rst, flush, wr, wd, rd, clr);
    #1;
    compare_all(tag);
  endtask

  task automatic push(input string tag, input logic [7:0] d);
    cycle(tag, 1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; wr_en_i = 1'b0; wr_data_i = 8'h00;
    rd_en_i = 1'b0; clr_err_i = 1'b0;
    @(posedge clk_i);
    #1;
    cycle("reset", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("reset.rdata0", 32'(rd_data_o), 32'h00);

    // Basic push/pop with hold of the last popped byte.
    push("t2.push", 8'hA5);
    push("t2.push", 8'h3C);
    pop("t2.pop1");
    check_eq("t2.first", 32'(rd_data_o), 32'hA5);
    pop("t2.pop2");
    check_eq("t2.second", 32'(rd_data_o), 32'h3C);
    cycle("t2.idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("t2.hold", 32'(rd_data_o), 32'h3C);

    // Fill to full, overflow, drain.
    for (int i = 0; i < 16; i++) begin
      push("t3.fill", 8'(i));
      if (i == 10) check_eq("t3.af11", 32'(almost_full_o), 32'd0);
      if (i == 11) check_eq("t3.af12", 32'(almost_full_o), 32'd1);
    end
    check_eq("t3.full", 32'(full_o), 32'd1);
    push("t3.ovf", 8'hFF);
    check_eq("t3.ovfflag", 32'(ovf_o), 32'd1);
    check_eq("t3.cnt16", 32'(count_o), 32'd16);
    for (int i = 0; i < 16; i++) begin
      pop("t3.drain");
      check_eq("t3.order", 32'(rd_data_o), 32'(i));
    end
    cycle("t3.clr", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous read/write while full, with pointer wrap.
    for (int i = 0; i < 16; i++) push("t4.fill", 8'(i));
    cycle("t4.rw", 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    check_eq("t4.cnt", 32'(count_o), 32'd16);
    check_eq("t4.noovf", 32'(ovf_o), 32'd0);
    check_eq("t4.rd0", 32'(rd_data_o), 32'h00);
    for (int i = 1; i < 16; i++) pop("t4.drain");
    pop("t4.last");
    check_eq("t4.wrapdata", 32'(rd_data_o), 32'h77);

    // Simultaneous read/write while empty.
    cycle("t5.rw", 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    check_eq("t5.udf", 32'(udf_o), 32'd1);
    check_eq("t5.cnt", 32'(count_o), 32'd1);
    check_eq("t5.noreadthru", 32'(rd_data_o), 32'h77);
    pop("t5.pop");
    check_eq("t5.data", 32'(rd_data_o), 32'h55);
    cycle("t5.clr", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("t5.udfclr", 32'(udf_o), 32'd0);

    // Error wins over clear in the same cycle.
    cycle("t5.errwin", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("t5.udfwin", 32'(udf_o), 32'd1);

    // Flush and reset with a write in the same cycle.
    for (int i = 0; i < 5; i++) push("t6.fill", 8'(8'h20 + i));
    cycle("t6.flush", 1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    check_eq("t6.fcnt", 32'(count_o), 32'd0);
    check_eq("t6.fempty", 32'(empty_o), 32'd1);
    check_eq("t6.fudf", 32'(udf_o), 32'd0);
    check_eq("t6.frdata", 32'(rd_data_o), 32'h55);
    for (int i = 0; i < 5; i++) push("t6.fill2", 8'(8'h30 + i));
    cycle("t6.rst", 1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
    check_eq("t6.rcnt", 32'(count_o), 32'd0);
    check_eq("t6.rrdata", 32'(rd_data_o), 32'h00);
    push("t6.after", 8'h42);
    pop("t6.after");
    check_eq("t6.afterdata", 32'(rd_data_o), 32'h42);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic r_rst, r_fl, r_wr, r_rd, r_clr;
      int bias;
      bias  = (n / 500) % 3;
      r_rst = ($urandom_range(0, 299) == 0);
      r_fl  = ($urandom_range(0, 149) == 0);
      r_wr  = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
      r_rd  = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
      r_clr = ($urandom_range(0, 19) == 0);
      cycle("rand", r_rst, r_fl, r_wr, 8'($urandom), r_rd, r_clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
